// File: rtl/rol32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rol32_seq
//  Description : Iterative rotate-left unit. Rotates the captured operand in
//                coarse steps of STEP bits, then finishes with single-bit
//                steps. Uses a start/busy/done handshake. This is the inverse
//                of the combinational rotate-right in the ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module rol32_seq #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5,
    parameter int STEP  = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] Ra,
    input  logic [SA_W-1:0]  shift_amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // State encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Coarse step expressed at counter width so comparisons stay width-matched
    localparam logic [SA_W-1:0] STEP_CNT = SA_W'(STEP);
    localparam logic [SA_W-1:0] ONE_CNT  = SA_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] work;
    logic [SA_W-1:0]  cnt;
    logic [WIDTH-1:0] rot_step;
    logic [WIDTH-1:0] rot_one;

    // Fixed rotations of the working register; wraparound, no fill bits
    assign rot_step = {work[WIDTH-STEP-1:0], work[WIDTH-1:WIDTH-STEP]};
    assign rot_one  = {work[WIDTH-2:0], work[WIDTH-1]};

    // State register; clear aborts any operation in flight
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath: capture on accept, one rotate action per SHIFT cycle,
    // publish result only when the remaining count reaches zero
    always_ff @(posedge clock) begin
        if (clear) begin
            work   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        work <= Ra;
                        cnt  <= shift_amt;
                    end
                end
                S_SHIFT: begin
                    if (cnt >= STEP_CNT) begin
                        work <= rot_step;
                        cnt  <= cnt - STEP_CNT;
                    end else if (cnt != '0) begin
                        work <= rot_one;
                        cnt  <= cnt - ONE_CNT;
                    end else begin
                        result <= work;
                    end
                end
                default: begin
                    work <= work;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rol32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rol32_seq
//  Description : Self-checking bench for rol32_seq. Expected results come from
//                a wide-shift rotate model; expected latency from n/STEP +
//                n%STEP + 2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rol32_seq;

    localparam int WIDTH = 32;
    localparam int SA_W  = 5;
    localparam int STEP  = 4;

    logic             clock;
    logic             clear;
    logic             start;
    logic [WIDTH-1:0] Ra;
    logic [SA_W-1:0]  shift_amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_result;

    rol32_seq #(.WIDTH(WIDTH), .SA_W(SA_W), .STEP(STEP)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .Ra        (Ra),
        .shift_amt (shift_amt),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference rotations: take the window of a doubled word
    function automatic logic [31:0] rol_ref(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [31:0] ror_ref(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One operation. Inputs are driven on the falling edge; outputs are
    // sampled on the falling edge. Optionally re-pulses start while busy and
    // again in the DONE cycle, both of which must be ignored.
    task automatic do_op(input string tag, input logic [31:0] a, input int n,
                         input bit poke_busy, input bit poke_done);
        int  edges;
        int  busy_cycles;
        int  exp_lat;
        bit  busy_ok;
        bit  hold_ok;
        exp_lat     = n / STEP + n % STEP + 2;
        busy_ok     = 1'b1;
        hold_ok     = 1'b1;
        busy_cycles = 0;
        @(negedge clock);
        start     = 1'b1;
        Ra        = a;
        shift_amt = SA_W'(n);
        @(negedge clock);
        edges     = 1;
        start     = 1'b0;
        Ra        = $urandom;
        shift_amt = SA_W'($urandom);
        while (!done && edges < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (result !== exp_result) hold_ok = 1'b0;
            busy_cycles++;
            if (poke_busy && edges == 1) begin
                start = 1'b1;
                Ra    = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            edges++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
        check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_result_stable"}, {31'd0, hold_ok}, 32'd1);
        exp_result = rol_ref(a, n);
        check({tag, "_result"}, result, exp_result);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        if (poke_done) begin
            start = 1'b1;
            Ra    = 32'h0BAD_0BAD;
        end
        @(negedge clock);
        start = 1'b0;
        check({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
        if (poke_done) begin
            @(negedge clock);
            check({tag, "_done_start_ignored"}, {30'd0, busy, done}, 32'd0);
        end
    endtask

    initial begin
        int   n;
        logic [31:0] x;
        clear      = 1'b1;
        start      = 1'b0;
        Ra         = '0;
        shift_amt  = '0;
        exp_result = '0;
        repeat (2) @(negedge clock);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        clear = 1'b0;

        do_op("t1_n0", 32'hF0F0_F0F0, 0, 1'b0, 1'b0);
        check("t1_value", result, 32'hF0F0_F0F0);
        do_op("t2_n4", 32'hF0F0_F0F0, 4, 1'b0, 1'b0);
        check("t2_value", result, 32'h0F0F_0F0F);
        do_op("t2_inverse", ror_ref(32'hF0F0_F0F0, 4), 4, 1'b0, 1'b0);
        check("t2_inverse_value", result, 32'hF0F0_F0F0);
        do_op("t3_n16", 32'h1234_5678, 16, 1'b0, 1'b0);
        check("t3_value", result, 32'h5678_1234);
        do_op("t4_n31", 32'hAAAA_AAAA, 31, 1'b0, 1'b0);
        check("t4_value", result, 32'h5555_5555);
        do_op("t5_n1", 32'h8000_0001, 1, 1'b1, 1'b1);
        check("t5_value", result, 32'h0000_0003);

        // Clear in flight: accept at edge 1, clear asserted for edge 4
        @(negedge clock);
        start     = 1'b1;
        Ra        = 32'hAAAA_AAAA;
        shift_amt = 5'd31;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear      = 1'b0;
        exp_result = '0;
        check("t6_clear_busy", {31'd0, busy}, 32'd0);
        check("t6_clear_done", {31'd0, done}, 32'd0);
        check("t6_clear_result", result, 32'd0);
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (14) begin
                @(negedge clock);
                if (done || busy) saw_done = 1'b1;
            end
            check("t6_no_done_after_clear", {31'd0, saw_done}, 32'd0);
        end
        do_op("t6_n8", 32'h1234_5678, 8, 1'b0, 1'b0);
        check("t6_value", result, 32'h3456_7812);

        // Randomised round trips through the inverse rotate
        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            n = int'($urandom_range(0, WIDTH - 1));
            do_op("rand", ror_ref(x, n), n, i[0], i[1]);
            check("rand_roundtrip", result, x);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
